// File: rtl/shifter_iter.sv
// ---------------------------------------------------------------------------
// shifter_iter
//
// Multi-cycle shifter shared beside the ALU. It accepts an operand, a shift
// amount and a mode (LSL, LSR, ASR, ROR). It then shifts a working copy by up
// to STEP bit positions per clock. The final value and the last bit shifted
// out are published together with a one-cycle done pulse.
//
// Parameters
//   WIDTH     operand width (power of 2, >= 4)
//   STEP      maximum shift applied per clock (1..WIDTH-1)
//   SW        shift-amount width, $clog2(WIDTH), derived
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   start      in   request, sampled only while idle
//   op         in   mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   d_in       in   operand
//   shamt      in   shift amount 0..WIDTH-1
//   busy       out  high whenever the engine is not idle
//   done       out  one-cycle pulse, d_out/carry valid
//   d_out      out  result register
//   carry      out  last bit shifted/rotated out
//   state_dbg  out  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake: a request is taken on any rising edge where start=1 and busy=0.
// While busy=1, start is ignored and nothing is queued. There is no
// backpressure on the result. done is high for exactly one cycle with the new
// d_out/carry, and busy is still high in that cycle. d_out/carry then hold
// until the next result replaces them.
// ---------------------------------------------------------------------------
module shifter_iter #(
    parameter  int WIDTH = 8,
    parameter  int STEP  = 3,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d_in,
    input  logic [SW-1:0]    shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d_out,
    output logic             carry,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [SW-1:0] STEP_V = SW'(STEP);

    state_t           state;
    logic [WIDTH-1:0] work;      // working value, never visible on d_out
    logic             work_c;    // last bit shifted out so far
    logic [SW-1:0]    rem;       // positions still to shift
    logic [1:0]       op_q;
    logic             sign_q;    // MSB of the original operand, ASR fill

    logic [SW-1:0]    k;         // positions shifted this clock
    logic [WIDTH-1:0] step_w;
    logic             step_c;

    assign state_dbg = state;

    assign k = (rem > STEP_V) ? STEP_V : rem;

    // One clock's worth of shifting is a chain of STEP single-bit stages.
    // Only the first k stages are enabled. The carry is the bit leaving on
    // the last enabled stage.
    always_comb begin
        step_w = work;
        step_c = work_c;
        for (int i = 0; i < STEP; i++) begin
            if (SW'(i) < k) begin
                unique case (op_q)
                    OP_LSL: begin
                        step_c = step_w[WIDTH-1];
                        step_w = {step_w[WIDTH-2:0], 1'b0};
                    end
                    OP_LSR: begin
                        step_c = step_w[0];
                        step_w = {1'b0, step_w[WIDTH-1:1]};
                    end
                    OP_ASR: begin
                        step_c = step_w[0];
                        step_w = {sign_q, step_w[WIDTH-1:1]};
                    end
                    OP_ROR: begin
                        step_c = step_w[0];
                        step_w = {step_w[0], step_w[WIDTH-1:1]};
                    end
                    default: begin
                        step_c = step_c;
                        step_w = step_w;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            d_out  <= '0;
            carry  <= 1'b0;
            work   <= '0;
            work_c <= 1'b0;
            rem    <= '0;
            op_q   <= OP_LSL;
            sign_q <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        sign_q <= d_in[WIDTH-1];
                        work   <= d_in;
                        work_c <= 1'b0;
                        rem    <= shamt;
                        busy   <= 1'b1;
                        if (shamt == '0) begin
                            // Nothing to shift: publish the operand directly.
                            d_out <= d_in;
                            carry <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work   <= step_w;
                    work_c <= step_c;
                    rem    <= rem - k;
                    if (rem == k) begin
                        d_out <= step_w;
                        carry <= step_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_iter.sv
// ---------------------------------------------------------------------------
// tb_shifter_iter
//
// Three shifter_iter instances (STEP = 1, 3, 7) share operand inputs. Each
// instance has its own start. Directed vectors run on the STEP=3 instance.
// A sweep drives all three together and compares them against a
// whole-shift reference function.
// ---------------------------------------------------------------------------
module tb_shifter_iter;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [2:0] start_v;
    logic [1:0] op;
    logic [7:0] d_in;
    logic [2:0] shamt;
    logic [2:0] busy_v, done_v, carry_v;
    logic [7:0] dout_v [3];
    logic [1:0] st_v   [3];

    int steps [3] = '{1, 3, 7};
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] last_exp;  // expected held result of the STEP=3 instance

    shifter_iter #(.WIDTH(8), .STEP(1)) dut_s1 (
        .clk(clk), .reset_n(reset_n), .start(start_v[0]), .op(op), .d_in(d_in),
        .shamt(shamt), .busy(busy_v[0]), .done(done_v[0]), .d_out(dout_v[0]),
        .carry(carry_v[0]), .state_dbg(st_v[0])
    );
    shifter_iter #(.WIDTH(8), .STEP(3)) dut_s3 (
        .clk(clk), .reset_n(reset_n), .start(start_v[1]), .op(op), .d_in(d_in),
        .shamt(shamt), .busy(busy_v[1]), .done(done_v[1]), .d_out(dout_v[1]),
        .carry(carry_v[1]), .state_dbg(st_v[1])
    );
    shifter_iter #(.WIDTH(8), .STEP(7)) dut_s7 (
        .clk(clk), .reset_n(reset_n), .start(start_v[2]), .op(op), .d_in(d_in),
        .shamt(shamt), .busy(busy_v[2]), .done(done_v[2]), .d_out(dout_v[2]),
        .carry(carry_v[2]), .state_dbg(st_v[2])
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole shift in one go, result in [7:0], carry in [8].
    function automatic logic [8:0] ref_shift(input logic [1:0] o, input logic [7:0] d,
                                             input logic [2:0] s);
        logic [7:0] r;
        logic       c;
        int         si;
        si = int'(s);
        case (o)
            LSL: begin r = d << si; c = (si == 0) ? 1'b0 : d[8-si]; end
            LSR: begin r = d >> si; c = (si == 0) ? 1'b0 : d[si-1]; end
            ASR: begin r = 8'($signed(d) >>> si); c = (si == 0) ? 1'b0 : d[si-1]; end
            default: begin
                r = (d >> si) | (d << (8 - si));
                c = (si == 0) ? 1'b0 : r[7];
            end
        endcase
        return {c, r};
    endfunction

    // ---------------- drivers ----------------
    // One request on the STEP=3 instance with hand-computed expectations.
    task automatic run3(input string tag, input logic [1:0] o, input logic [7:0] d,
                        input logic [2:0] s, input logic [7:0] exp_r, input logic exp_c);
        int lat;
        int exp_lat;
        lat = 0;
        exp_lat = (int'(s) + 2) / 3 + 1;
        @(negedge clk);
        op = o; d_in = d; shamt = s; start_v[1] = 1'b1;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            start_v[1] = 1'b0;
            if (done_v[1]) begin
                lat = n;
            end else if (n < exp_lat) begin
                check({tag, " busy"}, 32'(busy_v[1]), 32'd1);
                check({tag, " hold"}, 32'(dout_v[1]), 32'(last_exp));
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " d_out"}, 32'(dout_v[1]), 32'(exp_r));
        check({tag, " carry"}, 32'(carry_v[1]), 32'(exp_c));
        check({tag, " busy@done"}, 32'(busy_v[1]), 32'd1);
        last_exp = exp_r;
        @(negedge clk);
        check({tag, " done low"}, 32'(done_v[1]), 32'd0);
        check({tag, " idle"}, 32'(busy_v[1]), 32'd0);
        check({tag, " held"}, 32'(dout_v[1]), 32'(exp_r));
    endtask

    // One request to all three instances, compared against ref_shift.
    task automatic sweep_op(input logic [1:0] o, input logic [7:0] d, input logic [2:0] s);
        logic [8:0] e;
        int lat [3];
        string tg;
        e = ref_shift(o, d, s);
        lat = '{0, 0, 0};
        tg = $sformatf("sweep op%0d d%02h sh%0d", o, d, s);
        @(negedge clk);
        op = o; d_in = d; shamt = s; start_v = 3'b111;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start_v = 3'b000;
            for (int j = 0; j < 3; j++) begin
                if (done_v[j] && lat[j] == 0) begin
                    lat[j] = n;
                    check($sformatf("%s st%0d d_out", tg, steps[j]), 32'(dout_v[j]), 32'(e[7:0]));
                    check($sformatf("%s st%0d carry", tg, steps[j]), 32'(carry_v[j]), 32'(e[8]));
                end
            end
        end
        for (int j = 0; j < 3; j++)
            check($sformatf("%s st%0d latency", tg, steps[j]), lat[j],
                  (int'(s) + steps[j] - 1) / steps[j] + 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dones;
        reset_n = 1'b0; start_v = '0; op = LSL; d_in = '0; shamt = '0;
        last_exp = 8'h00;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy_v[1]), 32'd0);
        check("reset done", 32'(done_v[1]), 32'd0);
        check("reset d_out", 32'(dout_v[1]), 32'd0);
        check("reset carry", 32'(carry_v[1]), 32'd0);
        check("reset state", 32'(st_v[1]), 32'd0);
        reset_n = 1'b1;

        // Directed vectors, STEP=3.
        run3("asr96_5", ASR, 8'h96, 3'd5, 8'hFC, 1'b1);
        run3("lsl96_7", LSL, 8'h96, 3'd7, 8'h00, 1'b1);
        run3("ror96_3", ROR, 8'h96, 3'd3, 8'hD2, 1'b1);
        run3("lsrA5_0", LSR, 8'hA5, 3'd0, 8'hA5, 1'b0);
        run3("lsrA5_4", LSR, 8'hA5, 3'd4, 8'h0A, 1'b0);

        // start held high with changing operands during a 7-bit ASR.
        // The ASR ends at n=4. The request driven at n=5 (LSR F8 by 4) is the
        // next one accepted, and its result appears at n=8.
        @(negedge clk);
        op = ASR; d_in = 8'hC0; shamt = 3'd7; start_v[1] = 1'b1;
        dones = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done_v[1]) begin
                dones++;
                if (dones == 1) begin
                    check("spam lat1", n, 4);
                    check("spam d_out1", 32'(dout_v[1]), 32'h0FF);
                    check("spam carry1", 32'(carry_v[1]), 32'd1);
                end else begin
                    check("spam lat2", n, 8);
                    check("spam d_out2", 32'(dout_v[1]), 32'h00F);
                    check("spam carry2", 32'(carry_v[1]), 32'd1);
                end
            end
            if (n <= 4) begin
                start_v[1] = 1'b1;
                op = 2'(n); d_in = 8'($urandom_range(255)); shamt = 3'($urandom_range(7));
            end else if (n == 5) begin
                start_v[1] = 1'b1;
                op = LSR; d_in = 8'hF8; shamt = 3'd4;
            end else begin
                start_v[1] = 1'b0;
            end
        end
        check("spam done count", dones, 2);
        last_exp = 8'h0F;

        // Reset in the middle of SHIFT.
        @(negedge clk);
        op = ASR; d_in = 8'h96; shamt = 3'd7; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy_v[1]), 32'd0);
        check("abort done", 32'(done_v[1]), 32'd0);
        check("abort d_out", 32'(dout_v[1]), 32'd0);
        check("abort carry", 32'(carry_v[1]), 32'd0);
        check("abort state", 32'(st_v[1]), 32'd0);
        reset_n = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_v[1]) dones++;
        end
        check("abort no done", dones, 0);
        last_exp = 8'h00;
        run3("after_abort", LSL, 8'h4F, 3'd2, 8'h3C, 1'b1);

        // Sweep every op and shift amount at STEP = 1, 3 and 7.
        for (int o = 0; o < 4; o++)
            for (int s = 0; s < 8; s++)
                for (int t = 0; t < 30; t++)
                    sweep_op(2'(o), 8'($urandom_range(255)), 3'(s));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
